// File: rtl/regfile_pkg.sv
// ============================================================================
// regfile_pkg : shared types and helpers for the host-port register file
// Rev 1.0
// ============================================================================
`default_nettype none

package regfile_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    RDATA = 2'd2
  } host_state_e;

  localparam int CMD_WRITE_BIT = 7;

  function automatic int nbytes(input int xlen);
    return xlen / 8;
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_host_fsm.sv
// ============================================================================
// regfile_host_fsm : byte-serial host command decode, byte counter, shift
// buffer and write-request generation.  Rev 1.0
// ============================================================================
`default_nettype none

module regfile_host_fsm
  import regfile_pkg::*;
#(
  parameter int XLEN = 16,
  parameter int AW   = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [7:0]      host_in,
  input  logic            host_valid,
  output logic [AW-1:0]   cmd_idx,
  input  logic [XLEN-1:0] snap_dat,
  output logic [7:0]      host_out,
  output logic            host_out_valid,
  output logic            busy,
  output logic            wr_req,
  output logic [AW-1:0]   wr_idx,
  output logic [XLEN-1:0] wr_dat
);

  localparam int NB = nbytes(XLEN);
  localparam int CW = $clog2(NB) + 1;
  localparam logic [CW-1:0] LAST = CW'(NB - 1);

  host_state_e     state;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] shbuf;
  logic [AW-1:0]   idx_q;
  logic [XLEN-1:0] byte_ext;
  logic [XLEN-1:0] shift_in;

  // Bytes arrive LSB first: each new byte enters at the top and the buffer
  // shifts down, so after NB bytes the first byte sits in bits [7:0].
  assign byte_ext = XLEN'(host_in);
  assign shift_in = (shbuf >> 8) | (byte_ext << (XLEN - 8));

  assign cmd_idx = host_in[AW-1:0];
  assign wr_req  = (state == WDATA) && host_valid && (cnt == LAST);
  assign wr_idx  = idx_q;
  assign wr_dat  = shift_in;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      shbuf          <= '0;
      idx_q          <= '0;
      host_out       <= '0;
      host_out_valid <= 1'b0;
      busy           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (host_valid) begin
            idx_q <= host_in[AW-1:0];
            cnt   <= '0;
            busy  <= 1'b1;
            if (host_in[CMD_WRITE_BIT]) begin
              state <= WDATA;
            end else begin
              // First byte goes out immediately; the rest stays snapshotted.
              state          <= RDATA;
              host_out       <= snap_dat[7:0];
              host_out_valid <= 1'b1;
              shbuf          <= snap_dat >> 8;
            end
          end
        end

        WDATA: begin
          if (host_valid) begin
            shbuf <= shift_in;
            if (cnt == LAST) begin
              state <= IDLE;
              busy  <= 1'b0;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end

        RDATA: begin
          if (cnt == LAST) begin
            state          <= IDLE;
            busy           <= 1'b0;
            cnt            <= '0;
            host_out       <= '0;
            host_out_valid <= 1'b0;
          end else begin
            host_out <= shbuf[7:0];
            shbuf    <= shbuf >> 8;
            cnt      <= cnt + 1'b1;
          end
        end

        default: begin
          state          <= IDLE;
          busy           <= 1'b0;
          cnt            <= '0;
          host_out       <= '0;
          host_out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_hostport.sv
// ============================================================================
// regfile_hostport : NREGS x XLEN register file with two read ports, one core
// write port and a byte-serial host load/dump port.  Rev 1.0
// ============================================================================
`default_nettype none

module regfile_hostport
  import regfile_pkg::*;
#(
  parameter int XLEN    = 16,
  parameter int NREGS   = 8,
  parameter int ZERO_R0 = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(NREGS)-1:0] src1,
  input  logic [$clog2(NREGS)-1:0] src2,
  output logic [XLEN-1:0]          src1_dat,
  output logic [XLEN-1:0]          src2_dat,
  input  logic [$clog2(NREGS)-1:0] tgt,
  input  logic [XLEN-1:0]          tgt_dat,
  input  logic                     tgt_we,
  input  logic [7:0]               host_in,
  input  logic                     host_valid,
  output logic [7:0]               host_out,
  output logic                     host_out_valid,
  output logic                     busy
);

  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0] regs [NREGS];

  logic [AW-1:0]   cmd_idx;
  logic [XLEN-1:0] snap_dat;
  logic            wr_req;
  logic [AW-1:0]   wr_idx;
  logic [XLEN-1:0] wr_dat;
  logic            core_ok;
  logic            host_ok;

  generate
    if (ZERO_R0 != 0) begin : g_zero_r0
      assign src1_dat = (src1 == '0)    ? '0 : regs[src1];
      assign src2_dat = (src2 == '0)    ? '0 : regs[src2];
      assign snap_dat = (cmd_idx == '0) ? '0 : regs[cmd_idx];
      assign core_ok  = tgt_we && (tgt != '0);
      assign host_ok  = wr_req && (wr_idx != '0);
    end else begin : g_plain_r0
      assign src1_dat = regs[src1];
      assign src2_dat = regs[src2];
      assign snap_dat = regs[cmd_idx];
      assign core_ok  = tgt_we;
      assign host_ok  = wr_req;
    end
  endgenerate

  // The host commit is written last so it wins a same-index collision.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (core_ok) begin
        regs[tgt] <= tgt_dat;
      end
      if (host_ok) begin
        regs[wr_idx] <= wr_dat;
      end
    end
  end

  regfile_host_fsm #(
    .XLEN (XLEN),
    .AW   (AW)
  ) u_host_fsm (
    .clk            (clk),
    .rst_n          (rst_n),
    .host_in        (host_in),
    .host_valid     (host_valid),
    .cmd_idx        (cmd_idx),
    .snap_dat       (snap_dat),
    .host_out       (host_out),
    .host_out_valid (host_out_valid),
    .busy           (busy),
    .wr_req         (wr_req),
    .wr_idx         (wr_idx),
    .wr_dat         (wr_dat)
  );

endmodule

`default_nettype wire

// File: doc/regfile_hostport.md
Name: regfile_hostport

Overview:
- Parametrised successor to the core register file: NREGS x XLEN registers, two combinational read ports and one synchronous core write port.
- Adds an 8-bit byte-serial host port so an external controller can load and dump any register through the 8-bit IO pins while the core runs.
- Sits between the CPU datapath (src/tgt ports) and the top-level IO pins (host port).

Parameters:
XLEN, 16, register width in bits; must be a multiple of 8, range 8..64
NREGS, 8, register count; power of 2, range 2..128 (AW = clog2(NREGS) is derived internally)
ZERO_R0, 1, 1 = register 0 always reads 0 and ignores all writes; 0 = register 0 is ordinary

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  synchronous, active-low reset
src1  in  AW  core read port 1 index
src2  in  AW  core read port 2 index
src1_dat  out  XLEN  register[src1], combinational
src2_dat  out  XLEN  register[src2], combinational
tgt  in  AW  core write index
tgt_dat  in  XLEN  core write data
tgt_we  in  1  core write enable
host_in  in  8  host byte
host_valid  in  1  host byte strobe, one byte per cycle when high
host_out  out  8  byte returned to the host
host_out_valid  out  1  host_out is valid this cycle
busy  out  1  a host transaction is in progress (state is not IDLE)

Behaviour:
- Reset (rst_n low at an edge): all registers 0, FSM to IDLE, host_out 0, host_out_valid 0, busy 0. Reset mid-transaction aborts it; partial write bytes are discarded and no register changes.
- Core reads are combinational with no write bypass: a same-cycle write is visible only after the edge.
- Core write: register[tgt] <= tgt_dat at the edge when tgt_we=1. If ZERO_R0=1 and tgt=0, the write is ignored.
- Command byte, accepted in IDLE when host_valid=1:
  - bit7 = 1 selects write, 0 selects read.
  - bits[AW-1:0] are the register index; bits[6:AW] are ignored.
- Let NB = XLEN/8.
- IDLE -> WDATA (write command):
  - Accept NB bytes, least-significant byte first, each on a cycle with host_valid=1; cycles with host_valid=0 stall without timeout.
  - The register is written at the same edge that accepts the last byte, then the FSM returns to IDLE.
  - Assembled data is held in a separate XLEN shift buffer, so the register does not change until that final edge.
- IDLE -> RDATA (read command):
  - At the accepting edge, snapshot the register into the shift buffer; a register-0 read with ZERO_R0=1 snapshots 0.
  - For the next NB cycles, host_out_valid=1 and host_out carries bytes LSB first, one per cycle, without waiting on the host.
  - Then IDLE; host_out returns to 0 and host_out_valid to 0.
  - host_valid during RDATA is ignored and the byte is dropped.
- Snapshot semantics: a core write to the same register during RDATA does not alter the bytes being streamed.
- Collision at the host-write commit edge with a core write to the same index: the host write wins. Different indices: both writes take effect.
- busy = 1 in WDATA and RDATA; busy = 0 in IDLE, including the cycle the command byte arrives.
- A byte counter of width clog2(NB)+1 is used; it must never wrap, because the FSM leaves at count NB-1.

Decomposition:
- Shared package regfile_pkg holds:
  - host FSM state enum: IDLE, WDATA, RDATA
  - CMD_WRITE_BIT = 7
  - helper function nbytes(XLEN) = XLEN/8
- One natural sub-module: regfile_host_fsm, containing the command decode, byte counter, shift buffer and write-request outputs. The storage array and the write arbitration remain in the top.

Test Plan:
- Reset, then core write tgt=3, tgt_dat=16'hBEEF, tgt_we=1; next cycle src1=3 -> src1_dat=16'hBEEF, and src2=0 -> src2_dat=0.
- ZERO_R0=1, core write tgt=0, data 16'h1234 -> src1=0 still reads 0; a host read of r0 streams 00, 00.
- Host write: send 8'h85, then 8'h34, then (2 idle cycles) 8'h12 -> busy high from the cycle after 8'h85 until the final edge; r5=16'h1234 exactly after the last byte; r5 unchanged before it.
- Host read of r5=16'h1234 with command 8'h05 -> host_out_valid high for 2 cycles with host_out 8'h34 then 8'h12; a core write of r5=16'hFFFF in the first RDATA cycle does not change the streamed bytes.
- Collision: host write commit to r2 (16'hAAAA) on the same edge as core write r2=16'h5555 -> r2=16'hAAAA. Repeat with core tgt=4 -> r2=16'hAAAA and r4=16'h5555.
- Reset asserted after the first data byte of a write to r6 (previous value 16'h0F0F) -> all registers read 0, busy=0, host_out_valid=0. A subsequent data byte is treated as a new command.
- Parameter sweep: XLEN=32, NREGS=16 with host write 8'h8F, 78, 56, 34, 12 -> r15=32'h12345678; read back streams 78, 56, 34, 12.
